// File: rtl/wrr_arb_pkg.sv
// Shared constants, state encoding and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

  localparam int NREQ        = 4;
  localparam int QW          = 3;
  localparam int IDW         = 2;
  localparam int DEF_QUANTUM = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] id2onehot(input logic [IDW-1:0] id);
    return NREQ'(1) << id;
  endfunction

endpackage

// File: rtl/wrr_rr_pick.sv
// Wrapping first-set search: returns the first mask bit found scanning upward from start.
module wrr_rr_pick
  import wrr_arb_pkg::*;
(
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  start,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;

  // rot[k] is the request k positions after start, so the lowest set bit wins
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rot[gi] = mask[start + IDW'(gi)];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IDW'(k);
      end
    end
  end

  assign found = |rot;
  assign idx   = start + off;

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-port hold quanta (cfg_data+1 cycles).
// Optional WRR_ARB_LOCK_EN adds a lock input that stretches a hold past quantum expiry.
module wrr_arbiter #(
  parameter int NREQ = wrr_arb_pkg::NREQ,
  parameter int QW   = wrr_arb_pkg::QW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_sel,
  input  logic [QW-1:0]   cfg_data,
`ifdef WRR_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_id,
  output logic            grant_valid
);

  import wrr_arb_pkg::*;

  localparam logic [QW-1:0] CNT_ONE = QW'(1);

  state_t          state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [1:0]      id_reg, id_next;
  logic [1:0]      last_reg, last_next;
  logic [QW-1:0]   cnt_reg, cnt_next;
  logic [QW-1:0]   quanta_reg [NREQ];

  logic [NREQ-1:0] pick_mask;
  logic [1:0]      pick_start;
  logic [1:0]      pick_idx;
  logic            pick_found;
  logic            take_pick;
  logic            hold_locked;

  // Quantum register file; a write lands at the edge, so a grant on that edge sees the old value
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_quanta
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          quanta_reg[gi] <= QW'(DEF_QUANTUM);
        end else if (cfg_we && (cfg_sel == 2'(gi))) begin
          quanta_reg[gi] <= cfg_data;
        end
      end
    end
  endgenerate

`ifdef WRR_ARB_LOCK_EN
  assign hold_locked = req[id_reg] & lock[id_reg];
`else
  assign hold_locked = 1'b0;
`endif

  // In HOLD last_reg equals id_reg, and masking the holder makes it lowest priority
  assign pick_mask  = req & ~grant_reg;
  assign pick_start = last_reg + 2'd1;

  wrr_rr_pick u_pick (
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    id_next    = id_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    take_pick  = 1'b0;

    case (state_reg)
      IDLE: begin
        take_pick = pick_found;
      end
      HOLD: begin
        if (!req[id_reg]) begin
          if (pick_found) begin
            take_pick = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            id_next    = '0;
            cnt_next   = '0;
          end
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (!hold_locked) begin
          if (pick_found) begin
            take_pick = 1'b1;
          end else begin
            cnt_next = quanta_reg[id_reg];
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        id_next    = '0;
        cnt_next   = '0;
      end
    endcase

    // A new grant (from IDLE or as a bubble-free handover) always reloads the counter
    if (take_pick) begin
      state_next = HOLD;
      grant_next = id2onehot(pick_idx);
      id_next    = pick_idx;
      last_next  = pick_idx;
      cnt_next   = quanta_reg[pick_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      id_reg    <= '0;
      last_reg  <= 2'd3;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      id_reg    <= id_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_id    = id_reg;
  assign grant_valid = |grant_reg;

endmodule
